// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction-issue path: opcode classes,
// branch/memory subops, the halt encoding and the fetch sequencer states.
package isa_pkg;

  localparam logic [1:0] CLS_ALU = 2'd0;
  localparam logic [1:0] CLS_IMM = 2'd1;
  localparam logic [1:0] CLS_BR  = 2'd2;
  localparam logic [1:0] CLS_MEM = 2'd3;

  localparam logic [3:0] BR_ALW  = 4'd0;
  localparam logic [3:0] BR_NEG  = 4'd1;
  localparam logic [3:0] BR_POS  = 4'd2;
  localparam logic [3:0] BR_ZERO = 4'd3;

  localparam logic [3:0] MEM_CALL = 4'd4;
  localparam logic [3:0] MEM_RET  = 4'd5;

  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_REQ,
    ST_WAIT,
    ST_ISSUE,
    ST_RESOLVE,
    ST_HALT
  } fetchState_e;

endpackage

// File: rtl/ifetch_next_pc.sv
// Next-PC computation for the fetch sequencer: decodes the held instruction
// and produces the post-issue PC, the post-resolve PC and the resolve flag.
module ifetch_next_pc
  import isa_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       instruct,
  input  logic              redirectValid,
  input  logic [ADDR_W-1:0] redirectPc,
  input  logic              resolveNt,
  output logic [ADDR_W-1:0] issueNextPc,
  output logic [ADDR_W-1:0] resolveNextPc,
  output logic              needsResolve,
  output logic              isHalt,
  output logic              resolveDone
);

  logic [1:0]               cls;
  logic [3:0]               subop;
  logic                     isUncond;
  logic                     isCond;
  logic                     isCallRet;
  logic signed [ADDR_W-1:0] off;
  logic [ADDR_W-1:0]        seqPc;

  // The size cast sign-extends (or truncates) the 26-bit offset field to ADDR_W.
  function automatic logic signed [ADDR_W-1:0] signExtOff(input logic [25:0] field);
    logic signed [25:0] sField;
    sField = field;
    return ADDR_W'(sField);
  endfunction

  always_comb begin
    cls       = instruct[31:30];
    subop     = instruct[29:26];
    off       = signExtOff(instruct[25:0]);
    isHalt    = (instruct == HALT_WORD);
    isUncond  = (cls == CLS_BR) && (subop == BR_ALW);
    isCond    = (cls == CLS_BR) &&
                ((subop == BR_NEG) || (subop == BR_POS) || (subop == BR_ZERO));
    isCallRet = (cls == CLS_MEM) && ((subop == MEM_CALL) || (subop == MEM_RET));
    needsResolve = !isHalt && (isCond || isCallRet);

    seqPc       = pc + ADDR_W'(1);
    issueNextPc = isUncond ? (seqPc + $unsigned(off)) : seqPc;

    // A redirect takes priority over a simultaneous not-taken report.
    resolveDone   = redirectValid || resolveNt;
    resolveNextPc = redirectValid ? redirectPc : seqPc;
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction-issue sequencer: fetches one word at a time, holds it on
// instruct until accepted, and steps the PC. Optional counters: IFETCH_PERF_CNT_EN.
module instr_fetch_seq
  import isa_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       HALT_WORD = HALT_WORD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instruct,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              resolve_nt,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              seq_err
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]       issue_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  fetchState_e       state;
  fetchState_e       nextState;
  logic              fetching;
  logic              ackTaken;
  logic              issueAccept;
  logic              inResolve;
  logic              spurious;
  logic              doubleResolve;
  logic [ADDR_W-1:0] issueNextPc;
  logic [ADDR_W-1:0] resolveNextPc;
  logic              needsResolve;
  logic              isHalt;
  logic              resolveDone;

  ifetch_next_pc #(
    .ADDR_W    (ADDR_W),
    .HALT_WORD (HALT_WORD)
  ) uNextPc (
    .pc            (pc),
    .instruct      (instruct),
    .redirectValid (redirect_valid),
    .redirectPc    (redirect_pc),
    .resolveNt     (resolve_nt),
    .issueNextPc   (issueNextPc),
    .resolveNextPc (resolveNextPc),
    .needsResolve  (needsResolve),
    .isHalt        (isHalt),
    .resolveDone   (resolveDone)
  );

  always_comb begin
    fetching      = (state == ST_REQ) || (state == ST_WAIT);
    ackTaken      = fetching && imem_ack;
    issueAccept   = (state == ST_ISSUE) && instr_ready && !stall;
    inResolve     = (state == ST_RESOLVE);
    spurious      = (redirect_valid || resolve_nt) && !inResolve && (state != ST_HALT);
    doubleResolve = inResolve && redirect_valid && resolve_nt;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_REQ;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      ST_REQ, ST_WAIT: nextState = imem_ack ? ST_ISSUE : ST_WAIT;
      ST_ISSUE: begin
        if (issueAccept) begin
          if (isHalt)            nextState = ST_HALT;
          else if (needsResolve) nextState = ST_RESOLVE;
          else                   nextState = ST_REQ;
        end
      end
      ST_RESOLVE: if (resolveDone) nextState = ST_REQ;
      ST_HALT:    nextState = ST_HALT;
      default:    nextState = ST_REQ;
    endcase
  end

  // State-decoded outputs are masked while rst is held so they show reset values.
  always_comb begin
    imem_req    = fetching && !rst;
    instr_valid = (state == ST_ISSUE) && !rst;
    halted      = (state == ST_HALT) && !rst;
    imem_addr   = pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (issueAccept && !isHalt && !needsResolve) begin
      pc <= issueNextPc;
    end else if (inResolve && resolveDone) begin
      pc <= resolveNextPc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           instruct <= '0;
    else if (ackTaken) instruct <= imem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst)                          seq_err <= 1'b0;
    else if (spurious || doubleResolve) seq_err <= 1'b1;
  end

`ifdef IFETCH_PERF_CNT_EN
  function automatic logic [31:0] satInc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (issueAccept) issue_cnt <= satInc(issue_cnt);
      if ((state == ST_ISSUE) && (stall || !instr_ready)) stall_cnt <= satInc(stall_cnt);
    end
  end
`endif

endmodule
